// File: rtl/icache_control_pkg.sv
// Shared types and helpers for the 2-way instruction-cache control logic.
package icache_control_pkg;

  // Sequencer states: RUN serves hits and bubbles, FETCH waits for a line refill.
  typedef enum logic [0:0] {
    RUN   = 1'b0,
    FETCH = 1'b1
  } icache_state_t;

  // Way indices, matching the datapath's way numbering.
  localparam logic WAY0 = 1'b0;
  localparam logic WAY1 = 1'b1;

  // One-hot per-way write enable for the given way index.
  function automatic logic [1:0] way_onehot(input logic way);
    logic [1:0] oh;
    if (way == WAY1) begin
      oh = 2'b10;
    end else begin
      oh = 2'b01;
    end
    return oh;
  endfunction

endpackage

// File: rtl/icache_control_chk.sv
// Protocol checks on the stage-2 inputs of the cache sequencer.
module icache_control_chk
  import icache_control_pkg::*;
(
  input logic          clk,
  input logic          rst,
  input icache_state_t state_i,
  input logic          pipe_mem_read_i,
  input logic          hit_i,
  input logic          tag0_hit_i,
  input logic          tag1_hit_i
);

  // A line can live in at most one way.
  a_onehot_hit: assert property (@(posedge clk) disable iff (rst)
    ((state_i == RUN) && pipe_mem_read_i) |-> !(tag0_hit_i && tag1_hit_i));

  // The combined hit must agree with the per-way hits.
  a_hit_consistent: assert property (@(posedge clk) disable iff (rst)
    ((state_i == RUN) && pipe_mem_read_i) |-> (hit_i == (tag0_hit_i | tag1_hit_i)));

endmodule

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear (clear wins over increment).
module sat_counter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc_i,
  input  logic             clr_i,
  output logic [WIDTH-1:0] count_o
);

  logic [WIDTH-1:0] count_q, count_d;

  // Next count: clear first, then increment unless already at all-ones.
  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (inc_i && (count_q != {WIDTH{1'b1}})) begin
      count_d = count_q + {{(WIDTH-1){1'b0}}, 1'b1};
    end else begin
      count_d = count_q;
    end
  end

  // Count register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/icache_control.sv
// Sequencing FSM for the pipelined 2-way instruction cache: hits respond with
// zero stall, misses freeze stage 2 and refill the LRU victim way from memory.
module icache_control
  import icache_control_pkg::*;
#(
  parameter int unsigned CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 pipe_mem_read_i,
  input  logic                 hit_i,
  input  logic                 tag0_hit_i,
  input  logic                 tag1_hit_i,
  input  logic                 lru_out_i,
  input  logic                 pmem_resp_i,
  input  logic                 cnt_clear_i,
  output logic                 load_pipeline_o,
  output logic                 read_data_o,
  output logic [1:0]           load_data_o,
  output logic [1:0]           load_tag_o,
  output logic                 set_valid0_o,
  output logic                 set_valid1_o,
  output logic                 load_lru_o,
  output logic                 lru_wdata_o,
  output logic                 mem_resp_o,
  output logic                 pmem_read_o,
  output logic [CNT_WIDTH-1:0] hit_count_o,
  output logic [CNT_WIDTH-1:0] miss_count_o
);

  icache_state_t state_q, state_d;
  logic          victim_q, victim_d;
  logic          hit_inc_s;
  logic          miss_inc_s;

  // Next-state and output decode; reset forces the idle RUN outputs so that
  // no request, write or response can leak out while rst is high.
  always_comb begin
    state_d         = state_q;
    victim_d        = victim_q;
    load_pipeline_o = 1'b0;
    load_data_o     = 2'b00;
    load_tag_o      = 2'b00;
    set_valid0_o    = 1'b0;
    set_valid1_o    = 1'b0;
    load_lru_o      = 1'b0;
    lru_wdata_o     = 1'b0;
    mem_resp_o      = 1'b0;
    pmem_read_o     = 1'b0;
    hit_inc_s       = 1'b0;
    miss_inc_s      = 1'b0;
    if (rst) begin
      load_pipeline_o = 1'b1;
    end else begin
      case (state_q)
        RUN: begin
          if (!pipe_mem_read_i) begin
            load_pipeline_o = 1'b1;
          end else if (hit_i) begin
            // Point LRU at the way not just used; a double hit counts as way 1.
            load_pipeline_o = 1'b1;
            mem_resp_o      = 1'b1;
            load_lru_o      = 1'b1;
            lru_wdata_o     = tag0_hit_i & ~tag1_hit_i;
            hit_inc_s       = 1'b1;
          end else begin
            victim_d = lru_out_i;
            state_d  = FETCH;
          end
        end
        FETCH: begin
          if (pmem_resp_i) begin
            load_data_o     = way_onehot(victim_q);
            load_tag_o      = way_onehot(victim_q);
            set_valid0_o    = (victim_q == WAY0);
            set_valid1_o    = (victim_q == WAY1);
            load_lru_o      = 1'b1;
            lru_wdata_o     = ~victim_q;
            mem_resp_o      = 1'b1;
            load_pipeline_o = 1'b1;
            miss_inc_s      = 1'b1;
            state_d         = RUN;
          end else begin
            pmem_read_o = 1'b1;
          end
        end
        default: begin
          state_d = RUN;
        end
      endcase
    end
  end

  // State and victim-way registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= RUN;
      victim_q <= WAY0;
    end else begin
      state_q  <= state_d;
      victim_q <= victim_d;
    end
  end

  assign read_data_o = load_pipeline_o;

  sat_counter #(.WIDTH(CNT_WIDTH)) u_hit_cnt (
    .clk     (clk),
    .rst     (rst),
    .inc_i   (hit_inc_s),
    .clr_i   (cnt_clear_i),
    .count_o (hit_count_o)
  );

  sat_counter #(.WIDTH(CNT_WIDTH)) u_miss_cnt (
    .clk     (clk),
    .rst     (rst),
    .inc_i   (miss_inc_s),
    .clr_i   (cnt_clear_i),
    .count_o (miss_count_o)
  );

  icache_control_chk u_chk (
    .clk             (clk),
    .rst             (rst),
    .state_i         (state_q),
    .pipe_mem_read_i (pipe_mem_read_i),
    .hit_i           (hit_i),
    .tag0_hit_i      (tag0_hit_i),
    .tag1_hit_i      (tag1_hit_i)
  );

endmodule

// File: tb/tb_icache_control.sv
// Directed, table-driven bench for icache_control (32-bit and 4-bit counter builds).
module tb_icache_control;

  logic clk = 1'b0;
  logic rst;
  logic pmr, hit, t0, t1, lru, presp, clr;

  logic        lp, rd, sv0, sv1, llru, lw, mresp, pread;
  logic [1:0]  ld, lt;
  logic [31:0] hcnt, mcnt;

  logic        lp4, rd4, sv04, sv14, llru4, lw4, mresp4, pread4;
  logic [1:0]  ld4, lt4;
  logic [3:0]  hcnt4, mcnt4;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  icache_control #(.CNT_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .pipe_mem_read_i(pmr), .hit_i(hit), .tag0_hit_i(t0),
    .tag1_hit_i(t1), .lru_out_i(lru), .pmem_resp_i(presp), .cnt_clear_i(clr),
    .load_pipeline_o(lp), .read_data_o(rd), .load_data_o(ld), .load_tag_o(lt),
    .set_valid0_o(sv0), .set_valid1_o(sv1), .load_lru_o(llru), .lru_wdata_o(lw),
    .mem_resp_o(mresp), .pmem_read_o(pread), .hit_count_o(hcnt), .miss_count_o(mcnt)
  );

  icache_control #(.CNT_WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .pipe_mem_read_i(pmr), .hit_i(hit), .tag0_hit_i(t0),
    .tag1_hit_i(t1), .lru_out_i(lru), .pmem_resp_i(presp), .cnt_clear_i(clr),
    .load_pipeline_o(lp4), .read_data_o(rd4), .load_data_o(ld4), .load_tag_o(lt4),
    .set_valid0_o(sv04), .set_valid1_o(sv14), .load_lru_o(llru4), .lru_wdata_o(lw4),
    .mem_resp_o(mresp4), .pmem_read_o(pread4), .hit_count_o(hcnt4), .miss_count_o(mcnt4)
  );

  // Expected output packing: {lp, ld[1:0], lt[1:0], sv0, sv1, load_lru, lru_wdata, mem_resp, pmem_read}
  localparam logic [10:0] E_IDLE  = 11'b1_00_00_0_0_0_0_0_0;
  localparam logic [10:0] E_HIT0  = 11'b1_00_00_0_0_1_1_1_0;
  localparam logic [10:0] E_HIT1  = 11'b1_00_00_0_0_1_0_1_0;
  localparam logic [10:0] E_DET   = 11'b0_00_00_0_0_0_0_0_0;
  localparam logic [10:0] E_WAIT  = 11'b0_00_00_0_0_0_0_0_1;
  localparam logic [10:0] E_FILL0 = 11'b1_01_01_1_0_1_1_1_0;
  localparam logic [10:0] E_FILL1 = 11'b1_10_10_0_1_1_0_1_0;

  typedef struct {
    string       name;
    logic        pmr, hit, t0, t1, lru, presp, clr;
    logic [10:0] exp;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(input string name, input logic p, input logic h, input logic a,
                              input logic b, input logic l, input logic r, input logic c,
                              input logic [10:0] e);
    vec_t v;
    v.name = name; v.pmr = p; v.hit = h; v.t0 = a; v.t1 = b;
    v.lru = l; v.presp = r; v.clr = c; v.exp = e;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_outs(input string name, input logic [10:0] exp);
    check(name, {52'd0, rd, lp, ld, lt, sv0, sv1, llru, lw, mresp, pread}, {52'd0, exp[10], exp});
  endtask

  task automatic drive(input logic p, input logic h, input logic a, input logic b,
                       input logic l, input logic r, input logic c);
    pmr = p; hit = h; t0 = a; t1 = b; lru = l; presp = r; clr = c;
  endtask

  // Entered #1 after a rising edge; leaves #1 after the following rising edge.
  task automatic run_range(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      drive(vq[i].pmr, vq[i].hit, vq[i].t0, vq[i].t1, vq[i].lru, vq[i].presp, vq[i].clr);
      #2;
      check_outs(vq[i].name, vq[i].exp);
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    // 0-3: four back-to-back way-0 hits
    for (int i = 0; i < 4; i++) vq.push_back(mk("t1_hit0", 1, 1, 1, 0, 0, 0, 0, E_HIT0));
    // 4-10: miss, victim way 1, five waiting cycles (hit inputs ignored), then fill
    vq.push_back(mk("t2_detect", 1, 0, 0, 0, 1, 0, 0, E_DET));
    vq.push_back(mk("t2_wait",   1, 0, 0, 0, 1, 0, 0, E_WAIT));
    vq.push_back(mk("t2_wait",   1, 0, 0, 0, 1, 0, 0, E_WAIT));
    vq.push_back(mk("t2_waithit",1, 1, 1, 0, 0, 0, 0, E_WAIT));
    vq.push_back(mk("t2_wait",   1, 0, 0, 0, 1, 0, 0, E_WAIT));
    vq.push_back(mk("t2_wait",   1, 0, 0, 0, 1, 0, 0, E_WAIT));
    vq.push_back(mk("t2_fill1",  1, 0, 0, 0, 0, 1, 0, E_FILL1));
    // 11-15: miss into way 0, then immediate miss into way 1 with 1-cycle memory
    vq.push_back(mk("t3_detect0", 1, 0, 0, 0, 0, 0, 0, E_DET));
    vq.push_back(mk("t3_wait0",   1, 0, 0, 0, 1, 0, 0, E_WAIT));
    vq.push_back(mk("t3_fill0",   1, 0, 0, 0, 1, 1, 0, E_FILL0));
    vq.push_back(mk("t3_detect1", 1, 0, 0, 0, 1, 0, 0, E_DET));
    vq.push_back(mk("t3_fill1",   1, 0, 0, 0, 0, 1, 0, E_FILL1));
    // 16-19: bubbles with stray pmem_resp, then a way-1 hit
    for (int i = 0; i < 3; i++) vq.push_back(mk("t5_bubble", 0, 0, 0, 0, 1, 1, 0, E_IDLE));
    vq.push_back(mk("t5_hit1", 1, 1, 0, 1, 1, 0, 0, E_HIT1));
    // 20-22: miss and two waiting cycles before the reset
    vq.push_back(mk("t4_detect", 1, 0, 0, 0, 1, 0, 0, E_DET));
    vq.push_back(mk("t4_wait",   1, 0, 0, 0, 1, 0, 0, E_WAIT));
    vq.push_back(mk("t4_wait",   1, 0, 0, 0, 1, 0, 0, E_WAIT));
    // 23-42: twenty way-0 hits, 43: clear together with a hit, 44: one more hit
    for (int i = 0; i < 20; i++) vq.push_back(mk("t6_hit", 1, 1, 1, 0, 0, 0, 0, E_HIT0));
    vq.push_back(mk("t6_clr_hit", 1, 1, 1, 0, 0, 0, 1, E_HIT0));
    vq.push_back(mk("t6_hit_after", 1, 1, 1, 0, 0, 0, 0, E_HIT0));

    // Reset state
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0);
    #2;
    check_outs("reset_outs", E_IDLE);
    check("reset_hit_count", {32'd0, hcnt}, 64'd0);
    check("reset_miss_count", {32'd0, mcnt}, 64'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;

    run_range(0, 3);
    check("t1_hit_count", {32'd0, hcnt}, 64'd4);
    run_range(4, 10);
    check("t2_miss_count", {32'd0, mcnt}, 64'd1);
    check("t2_hit_count", {32'd0, hcnt}, 64'd4);
    run_range(11, 15);
    check("t3_miss_count", {32'd0, mcnt}, 64'd3);
    run_range(16, 19);
    check("t5_hit_count", {32'd0, hcnt}, 64'd5);
    check("t5_miss_count", {32'd0, mcnt}, 64'd3);

    // Reset while waiting on memory (now in the third FETCH cycle)
    run_range(20, 22);
    drive(1, 0, 0, 0, 1, 0, 0);
    #1;
    check_outs("t4_prereset_wait", E_WAIT);
    rst = 1'b1;
    #1;
    check_outs("t4_reset_async", E_IDLE);
    check("t4_reset_hit_count", {32'd0, hcnt}, 64'd0);
    check("t4_reset_miss_count", {32'd0, mcnt}, 64'd0);
    presp = 1'b1;
    @(posedge clk);
    #1;
    check_outs("t4_reset_resp_ignored", E_IDLE);
    rst = 1'b0;
    drive(0, 0, 0, 0, 1, 1, 0);
    #2;
    check_outs("t4_after_release", E_IDLE);
    @(posedge clk);
    #1;
    drive(0, 0, 0, 0, 1, 0, 0);
    #2;
    check_outs("t4_run_after_release", E_IDLE);
    check("t4_miss_count", {32'd0, mcnt}, 64'd0);
    @(posedge clk);
    #1;

    // Saturation on the 4-bit build, clear priority on both builds
    run_range(23, 42);
    check("t6_hit_count_sat4", {60'd0, hcnt4}, 64'd15);
    check("t6_hit_count_32", {32'd0, hcnt}, 64'd20);
    run_range(43, 43);
    check("t6_clr_hit_count_4", {60'd0, hcnt4}, 64'd0);
    check("t6_clr_hit_count_32", {32'd0, hcnt}, 64'd0);
    run_range(44, 44);
    check("t6_count_after_clr_4", {60'd0, hcnt4}, 64'd1);
    check("t6_miss_count_4", {60'd0, mcnt4}, 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
